// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Active-low glyph/anode constants and slot indices for the
//                seven-segment scanner.
//  Revision    : 1.0
// ============================================================================
package seg7_pkg;

  typedef logic [3:0] bcd_t;

  // Segment order is {a,b,c,d,e,f,g}; a 0 lights the segment.
  localparam logic [6:0] SEG_0    = 7'b0000001;
  localparam logic [6:0] SEG_1    = 7'b1001111;
  localparam logic [6:0] SEG_2    = 7'b0010010;
  localparam logic [6:0] SEG_3    = 7'b0000110;
  localparam logic [6:0] SEG_4    = 7'b1001100;
  localparam logic [6:0] SEG_5    = 7'b0100100;
  localparam logic [6:0] SEG_6    = 7'b0100000;
  localparam logic [6:0] SEG_7    = 7'b0001111;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0000100;
  localparam logic [6:0] SEG_DASH = 7'b1111110;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [3:0] AN_OFF   = 4'b1111;

  localparam logic [1:0] IDX_A    = 2'd0;
  localparam logic [1:0] IDX_B    = 2'd1;
  localparam logic [1:0] IDX_C    = 2'd2;
  localparam logic [1:0] IDX_D    = 2'd3;

  function automatic logic [3:0] anode_sel(input logic [1:0] idx);
    case (idx)
      IDX_A:   return 4'b0111;
      IDX_B:   return 4'b1011;
      IDX_C:   return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_seg7
//  Description : Combinational BCD digit to active-low segment pattern;
//                codes 10-15 render as a dash.
//  Revision    : 1.0
// ============================================================================
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan4.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan4
//  Description : 4-digit common-anode display scanner with digit latch and
//                per-slot anode-off guard. Define LEAD_ZERO_BLANK_EN to
//                suppress leading zeros in digits A..C.
//  Revision    : 1.0
// ============================================================================
module seg7_scan4
  import seg7_pkg::*;
#(
  parameter int DIV_W        = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic [3:0] D,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam logic [DIV_W-1:0] c_blank_lim = DIV_W'(BLANK_CYCLES);

  bcd_t             a_q, b_q, c_q, d_q;
  bcd_t             a_d, b_d, c_d, d_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic             w_term;
  bcd_t             w_digit;
  logic             w_lz;
  logic [2:0]       w_lead_zero;
  logic [6:0]       w_glyph;

  assign w_term = (div_q == {DIV_W{1'b1}});

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    c_d   = c_q;
    d_d   = d_q;
    if (load) begin
      a_d = A;
      b_d = B;
      c_d = C;
      d_d = D;
    end
    div_d = div_q + DIV_W'(1);
    idx_d = w_term ? idx_q + 2'd1 : idx_q;
  end

`ifdef LEAD_ZERO_BLANK_EN
  // A zero is leading only if every more-significant digit is also zero.
  assign w_lead_zero[0] = (a_q == 4'd0);
  assign w_lead_zero[1] = w_lead_zero[0] && (b_q == 4'd0);
  assign w_lead_zero[2] = w_lead_zero[1] && (c_q == 4'd0);
`else
  assign w_lead_zero = 3'b000;
`endif

  always_comb begin
    w_digit = d_q;
    w_lz    = 1'b0;
    case (idx_q)
      IDX_A: begin
        w_digit = a_q;
        w_lz    = w_lead_zero[0];
      end
      IDX_B: begin
        w_digit = b_q;
        w_lz    = w_lead_zero[1];
      end
      IDX_C: begin
        w_digit = c_q;
        w_lz    = w_lead_zero[2];
      end
      default: begin
        w_digit = d_q;
        w_lz    = 1'b0;
      end
    endcase
  end

  bcd_to_seg7 u_dec (
    .digit_i (w_digit),
    .seg_o   (w_glyph)
  );

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if ((div_q >= c_blank_lim) && !w_lz) begin
      an_d  = anode_sel(idx_q);
      seg_d = w_glyph;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      d_q   <= '0;
      div_q <= '0;
      idx_q <= IDX_A;
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      d_q   <= d_d;
      div_q <= div_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan4
//  Description : Scoreboard bench for seg7_scan4 (DIV_W=4, BLANK_CYCLES=2).
//  Revision    : 1.0
// ============================================================================
module tb_seg7_scan4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [3:0] A = 4'd0, B = 4'd0, C = 4'd0, D = 4'd0;
  logic [3:0] an;
  logic [6:0] seg;

  int total = 0;
  int bad   = 0;

  logic [3:0] q_an[$];
  logic [6:0] q_seg[$];

  logic [3:0] m_lat[4];
  int         m_div = 0;
  int         m_idx = 0;

  always #5 clk = ~clk;

  seg7_scan4 #(.DIV_W(4), .BLANK_CYCLES(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .A    (A),
    .B    (B),
    .C    (C),
    .D    (D),
    .an   (an),
    .seg  (seg)
  );

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111110;
    endcase
  endfunction

  function automatic void model_reset();
    m_div = 0;
    m_idx = 0;
    for (int i = 0; i < 4; i++) m_lat[i] = 4'd0;
  endfunction

  // Expected outputs after the coming edge, from the state held before it.
  function automatic void model_out(output logic [3:0] ea, output logic [6:0] es);
    logic [3:0] lz;
    logic [3:0] one;
    one = 4'b1000;
    lz  = 4'b0000;
`ifdef LEAD_ZERO_BLANK_EN
    lz[0] = (m_lat[0] == 4'd0);
    lz[1] = lz[0] && (m_lat[1] == 4'd0);
    lz[2] = lz[1] && (m_lat[2] == 4'd0);
`endif
    ea = 4'b1111;
    es = 7'b1111111;
    if (rst && m_div >= 2 && !lz[m_idx]) begin
      ea = ~(one >> m_idx);
      es = glyph(m_lat[m_idx]);
    end
  endfunction

  function automatic void model_step();
    if (!rst) begin
      model_reset();
    end else begin
      if (load) begin
        m_lat[0] = A;
        m_lat[1] = B;
        m_lat[2] = C;
        m_lat[3] = D;
      end
      if (m_div == 15) begin
        m_div = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_div = m_div + 1;
      end
    end
  endfunction

  task automatic tick();
    logic [3:0] ea;
    logic [6:0] es;
    model_out(ea, es);
    @(posedge clk);
    model_step();
    #1;
    q_an.push_back(ea);
    q_seg.push_back(es);
  endtask

  // Reset asserted shortly after an edge: outputs must drop before the next edge.
  task automatic tick_reset_mid();
    @(posedge clk);
    model_step();
    #1;
    rst = 1'b0;
    model_reset();
    q_an.push_back(4'b1111);
    q_seg.push_back(7'b1111111);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic load_digits(input logic [3:0] a, b, c, d);
    A = a; B = b; C = c; D = d;
    load = 1'b1;
    tick();
    load = 1'b0;
    A = 4'd8; B = 4'd8; C = 4'd8; D = 4'd8;
  endtask

  initial begin : monitor
    logic [3:0] ea;
    logic [6:0] es;
    forever begin
      @(negedge clk);
      if (q_an.size() > 0) begin
        ea = q_an.pop_front();
        es = q_seg.pop_front();
        total++;
        if (an !== ea || seg !== es) begin
          bad++;
          $display("FAIL scan t=%0t an=%b seg=%b expected an=%b seg=%b",
                   $time, an, seg, ea, es);
        end
      end
    end
  end

  initial begin : stimulus
    int guard;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      load = i[0];
      A = 4'(i + 1); B = 4'd9; C = 4'd3; D = 4'(i);
      tick();
    end
    load = 1'b0;
    rst  = 1'b1;
    run(3);

    load_digits(4'd4, 4'd9, 4'd3, 4'd4);
    run(70);
    load_digits(4'd1, 4'd2, 4'hC, 4'd5);
    run(66);
    load_digits(4'd0, 4'd0, 4'd0, 4'd7);
    run(66);
    load_digits(4'd0, 4'd0, 4'd0, 4'd0);
    run(66);
    load_digits(4'd0, 4'hA, 4'd0, 4'd1);
    run(66);

    // Load held across a slot's terminal count.
    guard = 0;
    while (m_div != 14 && guard < 64) begin
      tick();
      guard++;
    end
    A = 4'd8; B = 4'd6; C = 4'd2; D = 4'd0;
    load = 1'b1;
    run(3);
    load = 1'b0;
    run(66);

    // Reset in the middle of slot C with load active.
    guard = 0;
    while (!(m_idx == 2 && m_div == 7) && guard < 128) begin
      tick();
      guard++;
    end
    if (guard >= 128) begin
      total++;
      bad++;
      $display("FAIL slot_wait reached=%0d/%0d required=2/7", m_idx, m_div);
    end
    tick_reset_mid();
    A = 4'd9; B = 4'd9; C = 4'd9; D = 4'd9;
    load = 1'b1;
    run(2);
    load = 1'b0;
    rst  = 1'b1;
    run(24);

    repeat (2) @(negedge clk);
    if (q_an.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d required=0", q_an.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
